vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised raster timing generator: horizontal/vertical counters, sync, blanking,
//  pixel coordinates and frame event strobes for any VGA/SVGA/720p-class mode.
//  Sits between the pixel-clock strobe divider and the pixel pipeline/framebuffer reader.
//  Mode set by parameters. Sync polarity selectable. All outputs registered.
//  Counter wrap points are exact: H_TOTAL pixels per line, V_TOTAL lines per frame.
// PARAMETERS
//  H_ACTIVE    640  visible pixels per line
//  H_FP        16   horizontal front porch (pixels)
//  H_SYNC      96   horizontal sync width (pixels)
//  H_BP        48   horizontal back porch (pixels)
//  V_ACTIVE    480  visible lines per frame
//  V_FP        10   vertical front porch (lines)
//  V_SYNC      2    vertical sync width (lines)
//  V_BP        33   vertical back porch (lines)
//  HS_POL      0    asserted level of o_hs (0 = active-low)
//  VS_POL      0    asserted level of o_vs
//  FRAME_CNT_W 16   frame counter width (used only with VGA_FRAME_CNT_EN)
//  derived: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise;
//  X_W=$clog2(H_TOTAL); Y_W=$clog2(V_TOTAL)
// PORTS
//  i_clk        in   1      base clock
//  i_rst_n      in   1      asynchronous reset, active low
//  i_pix_stb    in   1      pixel strobe; counters advance only on cycles where it is high
//  i_restart    in   1      synchronous frame restart (genlock/resync)
//  o_hs         out  1      horizontal sync, level per HS_POL
//  o_vs         out  1      vertical sync, level per VS_POL
//  o_active     out  1      high inside the visible area
//  o_blanking   out  1      ~o_active
//  o_x          out  X_W    pixel column, saturates at H_ACTIVE-1 outside visible area
//  o_y          out  Y_W    pixel row, saturates at V_ACTIVE-1 outside visible area
//  o_line_end   out  1      one-clk pulse at the last pixel of every line
//  o_animate    out  1      one-clk pulse at the last pixel of line V_ACTIVE-1
//  o_frame_end  out  1      one-clk pulse at the last pixel of the frame
// BEHAVIOUR
//  - Counter order, both axes: active, front porch, sync, back porch (h=0,v=0 is first visible pixel).
//  - h in 0..H_TOTAL-1; on i_pix_stb: h==H_TOTAL-1 -> h=0, v++ (v==V_TOTAL-1 -> v=0); else h++.
//  - i_pix_stb low: counters hold. Outputs keep their decoded values; pulses stay 0.
//  - Outputs: registered decode of current counters.
//    Latency 1 i_clk from counter change to output change.
//  - o_hs = HS_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL; o_vs likewise on v.
//  - o_active = (h<H_ACTIVE)&&(v<V_ACTIVE); o_x=min(h,H_ACTIVE-1); o_y=min(v,V_ACTIVE-1).
//  - Pulses register (i_pix_stb && h==H_TOTAL-1 [&& v==...]); high exactly one i_clk.
//  - o_frame_end implies o_line_end in the same cycle. o_animate and o_frame_end never coincide
//    (V_TOTAL > V_ACTIVE is required).
//  - i_restart high: h=v=0 next clk. It overrides i_pix_stb and suppresses the pulses that cycle.
//  - i_rst_n low (async, any time incl. mid-line): h=v=0.
//    Also o_hs=~HS_POL, o_vs=~VS_POL, o_active=0, o_blanking=1, o_x=o_y=0, pulses 0.
//  - First output update after reset release: decode of h=v=0 (o_active=1).
//  - Elaboration check ($error): any porch/sync/active parameter < 1.
// CONFIGURATION
//  - VGA_FRAME_CNT_EN defined: adds port o_frame_cnt out FRAME_CNT_W.
//    It increments in the same cycle o_frame_end pulses and wraps 2^FRAME_CNT_W-1 -> 0.
//    Cleared by reset and by i_restart.
//  - Undefined: port and counter absent; FRAME_CNT_W ignored.
// TESTING
//  (small mode: H 8/2/3/3 -> H_TOTAL=16, V 4/1/2/1 -> V_TOTAL=8, HS_POL=VS_POL=0, i_pix_stb=1 unless noted)
//  1 reset release, run 16 clks -> o_x 0..7 then holds 7; o_active high for 8 clks.
//    o_hs low exactly while h=10..12. o_line_end single pulse at h=15.
//  2 run 2 frames -> o_vs low exactly during v=5..6; o_animate at h=15,v=3.
//    o_frame_end every 128 clks at h=15,v=7; o_animate/o_frame_end never coincide.
//  3 i_pix_stb high 1 clk in 4 -> frame_end period 512 clks.
//    Each pulse one clk wide; outputs stable between strobes.
//  4 i_restart at h=6,v=2 -> next decode h=0,v=0 (o_x=0,o_y=0,o_active=1); no pulse that cycle.
//  5 assert i_rst_n low mid-frame at v=5 -> outputs take reset values immediately (no clk edge needed).
//  6 VGA_FRAME_CNT_EN, FRAME_CNT_W=2 -> o_frame_cnt 0,1,2,3,0 across 5 frames; i_restart clears to 0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised raster timing generator with registered sync/blank/coord outputs
// Define VGA_FRAME_CNT_EN to add the wrapping o_frame_cnt output.
module vga_timing_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int FRAME_CNT_W = 16,
  localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int X_W        = $clog2(H_TOTAL),
  localparam int Y_W        = $clog2(V_TOTAL)
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_pix_stb,
  input  logic           i_restart,
  output logic           o_hs,
  output logic           o_vs,
  output logic           o_active,
  output logic           o_blanking,
  output logic [X_W-1:0] o_x,
  output logic [Y_W-1:0] o_y,
  output logic           o_line_end,
  output logic           o_animate,
  output logic           o_frame_end
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [FRAME_CNT_W-1:0] o_frame_cnt
`endif
);

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || FRAME_CNT_W < 1) begin : g_param_check
    $error("vga_timing_gen: active, porch, sync and counter widths must all be >= 1");
  end

  localparam logic [X_W-1:0] H_LAST = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0] H_ACT  = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] X_MAX  = X_W'(H_ACTIVE - 1);
  localparam logic [X_W-1:0] HS_BEG = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0] HS_END = X_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [Y_W-1:0] V_LAST = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0] V_ACT  = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] Y_MAX  = Y_W'(V_ACTIVE - 1);
  localparam logic [Y_W-1:0] VS_BEG = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0] VS_END = Y_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [X_W-1:0] h_q, h_d;
  logic [Y_W-1:0] v_q, v_d;
  logic           hs_q, hs_d;
  logic           vs_q, vs_d;
  logic           active_q, active_d;
  logic           blanking_q, blanking_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           line_end_q, line_end_d;
  logic           animate_q, animate_d;
  logic           frame_end_q, frame_end_d;
  logic           h_vis, v_vis, line_last;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (i_restart) begin
      h_d = '0;
      v_d = '0;
    end else if (i_pix_stb) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // Outputs decode the current counters, so they trail a counter change by one clock.
  always_comb begin
    h_vis       = (h_q < H_ACT);
    v_vis       = (v_q < V_ACT);
    line_last   = i_pix_stb && !i_restart && (h_q == H_LAST);
    active_d    = h_vis && v_vis;
    blanking_d  = !(h_vis && v_vis);
    x_d         = h_vis ? h_q : X_MAX;
    y_d         = v_vis ? v_q : Y_MAX;
    hs_d        = (h_q >= HS_BEG && h_q < HS_END) ? HS_POL : ~HS_POL;
    vs_d        = (v_q >= VS_BEG && v_q < VS_END) ? VS_POL : ~VS_POL;
    line_end_d  = line_last;
    animate_d   = line_last && (v_q == Y_MAX);
    frame_end_d = line_last && (v_q == V_LAST);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_q         <= '0;
      v_q         <= '0;
      hs_q        <= ~HS_POL;
      vs_q        <= ~VS_POL;
      active_q    <= 1'b0;
      blanking_q  <= 1'b1;
      x_q         <= '0;
      y_q         <= '0;
      line_end_q  <= 1'b0;
      animate_q   <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      h_q         <= h_d;
      v_q         <= v_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      active_q    <= active_d;
      blanking_q  <= blanking_d;
      x_q         <= x_d;
      y_q         <= y_d;
      line_end_q  <= line_end_d;
      animate_q   <= animate_d;
      frame_end_q <= frame_end_d;
    end
  end

  assign o_hs        = hs_q;
  assign o_vs        = vs_q;
  assign o_active    = active_q;
  assign o_blanking  = blanking_q;
  assign o_x         = x_q;
  assign o_y         = y_q;
  assign o_line_end  = line_end_q;
  assign o_animate   = animate_q;
  assign o_frame_end = frame_end_q;

`ifdef VGA_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  // Advances on the same edge that raises o_frame_end so both are visible together.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (i_restart) begin
      frame_cnt_d = '0;
    end else if (frame_end_d) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign o_frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench for vga_timing_gen in a 16x8 raster mode
module tb_vga_timing_gen;
`ifdef VGA_FRAME_CNT_EN
  localparam int NFR = 5;
`else
  localparam int NFR = 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pix_stb = 1'b1;
  logic       restart = 1'b0;
  logic       o_hs, o_vs, o_active, o_blanking;
  logic [3:0] o_x;
  logic [2:0] o_y;
  logic       o_line_end, o_animate, o_frame_end;
`ifdef VGA_FRAME_CNT_EN
  logic [1:0] o_frame_cnt;
`endif

  int total = 0;
  int bad = 0;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .FRAME_CNT_W(2)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_pix_stb(pix_stb),
    .i_restart(restart),
    .o_hs(o_hs),
    .o_vs(o_vs),
    .o_active(o_active),
    .o_blanking(o_blanking),
    .o_x(o_x),
    .o_y(o_y),
    .o_line_end(o_line_end),
    .o_animate(o_animate),
    .o_frame_end(o_frame_end)
`ifdef VGA_FRAME_CNT_EN
    ,
    .o_frame_cnt(o_frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_hs"}, 32'(o_hs), 1);
    check({pfx, "_vs"}, 32'(o_vs), 1);
    check({pfx, "_active"}, 32'(o_active), 0);
    check({pfx, "_blank"}, 32'(o_blanking), 1);
    check({pfx, "_x"}, 32'(o_x), 0);
    check({pfx, "_y"}, 32'(o_y), 0);
    check({pfx, "_pulses"}, 32'({o_line_end, o_animate, o_frame_end}), 0);
  endtask

  int h, v, last_fe, fe_seen, prev_fe;
  logic [11:0] prev_vec;

  initial begin
    #12;
    check_reset_vals("rst");
    rst_n = 1'b1;

    // Free-running: sample n shows the decode of counter position n.
    last_fe = -1;
    for (int n = 0; n < NFR * 128; n++) begin
      h = n % 16;
      v = (n / 16) % 8;
      tick;
      if (n < 16) begin
        check("l0_x", 32'(o_x), (h < 8) ? h : 7);
        check("l0_active", 32'(o_active), (h < 8) ? 1 : 0);
        check("l0_blank", 32'(o_blanking), (h < 8) ? 0 : 1);
        check("l0_hs", 32'(o_hs), (h >= 10 && h <= 12) ? 0 : 1);
        check("l0_line_end", 32'(o_line_end), (h == 15) ? 1 : 0);
      end
      check("fr_y", 32'(o_y), (v < 4) ? v : 3);
      check("fr_vs", 32'(o_vs), (v == 5 || v == 6) ? 0 : 1);
      check("fr_animate", 32'(o_animate), (h == 15 && v == 3) ? 1 : 0);
      check("fr_frame_end", 32'(o_frame_end), (h == 15 && v == 7) ? 1 : 0);
      check("fr_fe_implies_le", 32'(o_frame_end && !o_line_end), 0);
      check("fr_anim_fe_excl", 32'(o_animate && o_frame_end), 0);
`ifdef VGA_FRAME_CNT_EN
      check("fr_cnt", 32'(o_frame_cnt), ((n + 1) / 128) % 4);
`endif
      if (o_frame_end) begin
        if (last_fe >= 0) check("fr_period", n - last_fe, 128);
        last_fe = n;
      end
    end

    // Strobe one clock in four; counter is back at h=0,v=0 here.
    last_fe = -1;
    fe_seen = 0;
    prev_fe = 0;
    prev_vec = {o_hs, o_vs, o_active, o_x, o_y, 2'b00};
    for (int i = 0; i < 1200; i++) begin
      pix_stb = (i % 4 == 0);
      tick;
      if (i % 4 != 0) check("stb_no_pulse", 32'({o_line_end, o_animate, o_frame_end}), 0);
      if (prev_fe != 0) check("stb_fe_width", 32'(o_frame_end), 0);
      if (i > 0 && i % 4 != 1) check("stb_stable", 32'({o_hs, o_vs, o_active, o_x, o_y, 2'b00}), 32'(prev_vec));
      if (o_frame_end) begin
        fe_seen++;
        if (last_fe >= 0) check("stb_fe_period", i - last_fe, 512);
        last_fe = i;
      end
      prev_fe = int'(o_frame_end);
      prev_vec = {o_hs, o_vs, o_active, o_x, o_y, 2'b00};
    end
    check("stb_fe_seen", 32'(fe_seen >= 2), 1);
    pix_stb = 1'b1;

    // Restart from h=6,v=2.
    restart = 1'b1;
    tick;
    restart = 1'b0;
`ifdef VGA_FRAME_CNT_EN
    check("rs_cnt_clr", 32'(o_frame_cnt), 0);
`endif
    repeat (38) tick;
    restart = 1'b1;
    tick;
    restart = 1'b0;
    check("rs_pre_x", 32'(o_x), 6);
    check("rs_pre_y", 32'(o_y), 2);
    tick;
    check("rs_x", 32'(o_x), 0);
    check("rs_y", 32'(o_y), 0);
    check("rs_active", 32'(o_active), 1);

    // Restart on the last pixel of the frame must swallow the pulses.
    restart = 1'b1;
    tick;
    restart = 1'b0;
    repeat (127) tick;
    restart = 1'b1;
    tick;
    restart = 1'b0;
    check("rs_last_pulses", 32'({o_line_end, o_animate, o_frame_end}), 0);
    check("rs_last_x", 32'(o_x), 7);
    check("rs_last_y", 32'(o_y), 3);
    check("rs_last_active", 32'(o_active), 0);
`ifdef VGA_FRAME_CNT_EN
    check("rs_last_cnt", 32'(o_frame_cnt), 0);
`endif

    // Asynchronous reset in the vertical sync region.
    repeat (82) tick;
    check("ar_vs_before", 32'(o_vs), 0);
    check("ar_y_before", 32'(o_y), 3);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_vals("ar");
    tick;
    check_reset_vals("ar_hold");
    #3;
    rst_n = 1'b1;
    tick;
    check("ar_first_active", 32'(o_active), 1);
    check("ar_first_x", 32'(o_x), 0);
    check("ar_first_y", 32'(o_y), 0);
    check("ar_first_sync", 32'({o_hs, o_vs}), 3);
    tick;
    check("ar_second_x", 32'(o_x), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
